// File: rtl/simd_mac_accumulator.sv
// Per-lane saturating accumulator for SIMD multiplier products (1x int8, 2x int4 or 4x int2).
// Sums DEPTH accepted beats per group and presents the lane sums on a registered valid/ready port.
module simd_mac_accumulator #(
  parameter int ACC_W = 24,
  parameter int DEPTH = 16,
  parameter int CNT_W = 5
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               clear,
  input  logic [1:0]         mode,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [15:0]        prod_int8,
  input  logic [7:0]         prod_int4_0,
  input  logic [7:0]         prod_int4_1,
  input  logic [3:0]         prod_int2_0,
  input  logic [3:0]         prod_int2_1,
  input  logic [3:0]         prod_int2_2,
  input  logic [3:0]         prod_int2_3,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [4*ACC_W-1:0] out_acc,
  output logic [1:0]         out_mode,
  output logic [3:0]         out_ovf
);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic [1:0]       beat_mode;
  logic [ACC_W-1:0] lane_acc  [4];
  logic [ACC_W-1:0] lane_prod [4];
  logic [ACC_W-1:0] lane_base [4];
  logic [ACC_W:0]   lane_wide [4];
  logic [ACC_W-1:0] lane_sum  [4];
  logic [3:0]       lane_sat;

  // The first beat of a group takes its mode from the port and starts from zero;
  // later beats reuse the latched group mode so mid-group mode changes are ignored.
  always_comb begin
    beat_mode  = (state == IDLE) ? mode : out_mode;
    count_next = count + 1'b1;
    lane_sat   = '0;
    for (int i = 0; i < 4; i++) begin
      lane_prod[i] = '0;
      lane_base[i] = '0;
      lane_wide[i] = '0;
      lane_sum[i]  = '0;
    end
    case (beat_mode)
      2'd1: begin
        lane_prod[0] = ACC_W'(prod_int4_0);
        lane_prod[1] = ACC_W'(prod_int4_1);
      end
      2'd2: begin
        lane_prod[0] = ACC_W'(prod_int2_0);
        lane_prod[1] = ACC_W'(prod_int2_1);
        lane_prod[2] = ACC_W'(prod_int2_2);
        lane_prod[3] = ACC_W'(prod_int2_3);
      end
      default: lane_prod[0] = ACC_W'(prod_int8);
    endcase
    for (int i = 0; i < 4; i++) begin
      lane_base[i] = (state == IDLE) ? '0 : lane_acc[i];
      lane_wide[i] = {1'b0, lane_base[i]} + {1'b0, lane_prod[i]};
      lane_sat[i]  = lane_wide[i][ACC_W];
      lane_sum[i]  = lane_sat[i] ? {ACC_W{1'b1}} : lane_wide[i][ACC_W-1:0];
    end
  end

  always_comb begin
    out_acc = '0;
    for (int i = 0; i < 4; i++) begin
      out_acc[i*ACC_W +: ACC_W] = lane_acc[i];
    end
  end

  // Group FSM; the lane registers double as the held result while draining.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= IDLE;
      count     <= '0;
      out_mode  <= 2'd0;
      out_ovf   <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      for (int i = 0; i < 4; i++) lane_acc[i] <= '0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (clear) begin
            state    <= IDLE;
            count    <= '0;
            out_ovf  <= '0;
            in_ready <= 1'b1;
            for (int i = 0; i < 4; i++) lane_acc[i] <= '0;
          end else if (in_valid) begin
            if (state == IDLE) out_mode <= mode;
            for (int i = 0; i < 4; i++) lane_acc[i] <= lane_sum[i];
            out_ovf <= out_ovf | lane_sat;
            count   <= count_next;
            if (count_next == DEPTH_C) begin
              state     <= DRAIN;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              state <= ACCUM;
            end
          end
        end
        DRAIN: begin
          if (out_ready) begin
            state     <= IDLE;
            count     <= '0;
            out_ovf   <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            for (int i = 0; i < 4; i++) lane_acc[i] <= '0;
          end
        end
        default: begin
          state     <= IDLE;
          count     <= '0;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_simd_mac_accumulator.sv
// Bench for simd_mac_accumulator: directed vectors, a group-level reference model and per-cycle compare.
module tb_simd_mac_accumulator;

  localparam int ACC_W = 16;
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;
  localparam int MAXV  = (1 << ACC_W) - 1;

  logic               clk = 1'b0;
  logic               nrst = 1'b0;
  logic               clear = 1'b0;
  logic [1:0]         mode = 2'd0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [15:0]        prod_int8 = '0;
  logic [7:0]         prod_int4_0 = '0, prod_int4_1 = '0;
  logic [3:0]         prod_int2_0 = '0, prod_int2_1 = '0, prod_int2_2 = '0, prod_int2_3 = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [4*ACC_W-1:0] out_acc;
  logic [1:0]         out_mode;
  logic [3:0]         out_ovf;

  int checks = 0;
  int errors = 0;

  simd_mac_accumulator #(.ACC_W(ACC_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .nrst(nrst), .clear(clear), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready),
    .prod_int8(prod_int8), .prod_int4_0(prod_int4_0), .prod_int4_1(prod_int4_1),
    .prod_int2_0(prod_int2_0), .prod_int2_1(prod_int2_1),
    .prod_int2_2(prod_int2_2), .prod_int2_3(prod_int2_3),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_acc(out_acc), .out_mode(out_mode), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a group is a list of accepted beats, each lane is a plain clamped integer sum.
  int         m_sum [4];
  logic [3:0] m_ovf;
  int         m_cnt;
  logic [1:0] m_mode;
  logic       m_busy;

  task automatic m_add(input int lane, input int p);
    int s;
    s = m_sum[lane] + p;
    if (s > MAXV) begin
      s = MAXV;
      m_ovf[lane] = 1'b1;
    end
    m_sum[lane] = s;
  endtask

  task automatic m_zero();
    for (int i = 0; i < 4; i++) m_sum[i] = 0;
    m_ovf = '0;
    m_cnt = 0;
  endtask

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      m_zero();
      m_mode = 2'd0;
      m_busy = 1'b0;
    end else if (m_busy) begin
      if (out_ready) begin
        m_busy = 1'b0;
        m_zero();
      end
    end else if (clear) begin
      m_zero();
    end else if (in_valid) begin
      if (m_cnt == 0) m_mode = mode;
      case (m_mode)
        2'd1: begin m_add(0, prod_int4_0); m_add(1, prod_int4_1); end
        2'd2: begin
          m_add(0, prod_int2_0); m_add(1, prod_int2_1);
          m_add(2, prod_int2_2); m_add(3, prod_int2_3);
        end
        default: m_add(0, prod_int8);
      endcase
      m_cnt++;
      if (m_cnt == DEPTH) m_busy = 1'b1;
    end
  end

  // Per-cycle compare on the falling edge, away from the active edge.
  always @(negedge clk) begin
    logic [4*ACC_W-1:0] exp_acc;
    if (nrst) begin
      check("in_ready", 64'(in_ready), 64'(!m_busy));
      check("out_valid", 64'(out_valid), 64'(m_busy));
      if (m_busy) begin
        exp_acc = '0;
        for (int i = 0; i < 4; i++) exp_acc[i*ACC_W +: ACC_W] = m_sum[i][ACC_W-1:0];
        check("out_acc", 64'(out_acc), 64'(exp_acc));
        check("out_mode", 64'(out_mode), 64'(m_mode));
        check("out_ovf", 64'(out_ovf), 64'(m_ovf));
      end
    end
  end

  task automatic apply_stimulus(input logic v, input logic [1:0] m, input logic [15:0] p8,
                                input logic [7:0] a, input logic [7:0] b,
                                input logic [3:0] c0, input logic [3:0] c1,
                                input logic [3:0] c2, input logic [3:0] c3,
                                input logic clr, input logic ordy);
    in_valid = v; mode = m; prod_int8 = p8;
    prod_int4_0 = a; prod_int4_1 = b;
    prod_int2_0 = c0; prod_int2_1 = c1; prod_int2_2 = c2; prod_int2_3 = c3;
    clear = clr; out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic beat8(input logic [15:0] p8);
    apply_stimulus(1'b1, 2'd0, p8, 8'd0, 8'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic idle_cycle(input logic ordy);
    apply_stimulus(1'b0, 2'd0, 16'd0, 8'd0, 8'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, ordy);
  endtask

  task automatic check_output(input string name, input logic v, input logic [63:0] acc,
                              input logic [1:0] m, input logic [3:0] ovf);
    check({name, ".valid"}, 64'(out_valid), 64'(v));
    check({name, ".acc"}, 64'(out_acc), acc);
    check({name, ".mode"}, 64'(out_mode), 64'(m));
    check({name, ".ovf"}, 64'(out_ovf), 64'(ovf));
  endtask

  initial begin
    logic [63:0] held;
    #12;
    check_output("reset", 1'b0, 64'd0, 2'd0, 4'd0);
    nrst = 1'b1;
    @(posedge clk);
    #1;
    check("reset.in_ready", 64'(in_ready), 64'd1);

    // int8 group of four beats
    beat8(16'd100); beat8(16'd200); beat8(16'd300);
    check("t1.not_yet", 64'(out_valid), 64'd0);
    beat8(16'd400);
    check_output("t1", 1'b1, 64'd1000, 2'd0, 4'd0);
    idle_cycle(1'b1);
    check("t1.drained", 64'(out_valid), 64'd0);

    // int4 group, mode switched to int2 after beat 2
    for (int i = 0; i < 4; i++)
      apply_stimulus(1'b1, (i < 2) ? 2'd1 : 2'd2, 16'd7, 8'd15, 8'd225,
                     4'd3, 4'd3, 4'd3, 4'd3, 1'b0, 1'b0);
    check_output("t2", 1'b1, {32'd0, 16'd900, 16'd60}, 2'd1, 4'd0);
    idle_cycle(1'b1);

    // int2 group with gaps in in_valid
    for (int i = 0; i < 7; i++) begin
      apply_stimulus((i % 2) == 0, 2'd2, 16'd0, 8'd0, 8'd0, 4'd1, 4'd2, 4'd4, 4'd9, 1'b0, 1'b0);
      if (i == 5) check("t3.not_yet", 64'(out_valid), 64'd0);
    end
    check_output("t3", 1'b1, {16'd36, 16'd16, 16'd8, 16'd4}, 2'd2, 4'd0);

    // back-pressure in DRAIN with beats offered
    held = out_acc;
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1'b1, 2'd0, 16'd50, 8'd1, 8'd1, 4'd1, 4'd1, 4'd1, 4'd1, 1'b0, 1'b0);
      check("t4.in_ready", 64'(in_ready), 64'd0);
      check("t4.stable", 64'(out_acc), held);
    end
    apply_stimulus(1'b1, 2'd0, 16'd50, 8'd1, 8'd1, 4'd1, 4'd1, 4'd1, 4'd1, 1'b0, 1'b1);
    check("t4.drop", 64'(out_valid), 64'd0);
    for (int i = 0; i < 4; i++) beat8(16'd5);
    check_output("t4.new", 1'b1, 64'd20, 2'd0, 4'd0);
    idle_cycle(1'b1);

    // saturation
    for (int i = 0; i < 4; i++) beat8(16'd65025);
    check_output("t5", 1'b1, 64'd65535, 2'd0, 4'b0001);
    idle_cycle(1'b1);
    check("t5.ovf_cleared", 64'(out_ovf), 64'd0);

    // clear mid-group drops the presented beat, then clear in DRAIN is ignored
    beat8(16'd7); beat8(16'd7);
    apply_stimulus(1'b1, 2'd0, 16'd7, 8'd0, 8'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) beat8(16'd1);
    check_output("t6.clear", 1'b1, 64'd4, 2'd0, 4'd0);
    apply_stimulus(1'b0, 2'd0, 16'd0, 8'd0, 8'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0);
    check_output("t6.clear_drain", 1'b1, 64'd4, 2'd0, 4'd0);
    idle_cycle(1'b1);

    // async reset while draining an int4 group
    for (int i = 0; i < 4; i++)
      apply_stimulus(1'b1, 2'd1, 16'd0, 8'd2, 8'd3, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    check_output("t6.pre_rst", 1'b1, {32'd0, 16'd12, 16'd8}, 2'd1, 4'd0);
    #2 nrst = 1'b0;
    #1;
    check_output("t6.async_rst", 1'b0, 64'd0, 2'd0, 4'd0);
    @(posedge clk);
    #1 nrst = 1'b1;
    idle_cycle(1'b0);
    check("t6.post_rst_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 4; i++) beat8(16'd9);
    check_output("t6.post_rst", 1'b1, 64'd36, 2'd0, 4'd0);
    idle_cycle(1'b1);
    idle_cycle(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
